// File: rtl/analogizer_video_pkg.sv
// Shared video definitions for the Analogizer output path: counter width default,
// RGB width and sync polarity, plus the registered output bundle type.
package analogizer_video_pkg;

  localparam int   CNT_W_DEF   = 12;
  localparam int   RGB_W       = 24;
  // All syncs on this path are active-high; csync gaps drive the inactive level.
  localparam logic SYNC_ACTIVE = 1'b1;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic csync;
    logic de;
    rgb_t rgb;
  } vid_out_t;

endpackage

// File: rtl/analogizer_csync_gen_if.sv
// Video bus between the core (master) and the composite-sync generator (slave).
interface analogizer_csync_gen_if;
  import analogizer_video_pkg::*;

  logic ce;
  logic hsync;
  logic vsync;
  logic de;
  rgb_t din;

  logic hsync_o;
  logic vsync_o;
  logic csync_o;
  logic de_o;
  rgb_t dout;
  logic locked;

  modport master (
    output ce, hsync, vsync, de, din,
    input  hsync_o, vsync_o, csync_o, de_o, dout, locked
  );

  modport slave (
    input  ce, hsync, vsync, de, din,
    output hsync_o, vsync_o, csync_o, de_o, dout, locked
  );

endinterface

// File: rtl/csync_line_meter.sv
// Line meter: hsync edge detect, in-line pixel position, hsync width, line length
// and a lock flag that is set once two consecutive lines measure identically.
module csync_line_meter
  import analogizer_video_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_i,
  input  logic             hsync_i,
  output logic [CNT_W-1:0] h_pos_o,     // position of the current pixel
  output logic [CNT_W-1:0] hs_width_o,
  output logic [CNT_W:0]   line_len_o,
  output logic             pos_sat_o,
  output logic             locked_o
);

  localparam logic [CNT_W-1:0] POS_MAX = '1;

  logic             hs_prev_q;
  logic [CNT_W-1:0] h_pos_q, h_pos_d;
  logic [CNT_W-1:0] hs_cnt_q, hs_cnt_d;
  logic [CNT_W-1:0] hs_width_q, hs_width_d;
  logic [CNT_W:0]   line_len_q, line_len_d;
  logic             locked_q, locked_d;
  logic             rise, fall;

  assign rise = hsync_i & ~hs_prev_q;
  assign fall = ~hsync_i & hs_prev_q;

  // NOTE: every variable gets its hold value before any branch, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    h_pos_d    = h_pos_q;
    hs_cnt_d   = hs_cnt_q;
    hs_width_d = hs_width_q;
    line_len_d = line_len_q;
    locked_d   = locked_q;
    if (ce_i) begin
      if (rise)                    h_pos_d = '0;
      else if (h_pos_q != POS_MAX) h_pos_d = h_pos_q + CNT_W'(1);

      // The rising-edge pixel is itself high, so the count restarts at 1.
      if (rise)                                 hs_cnt_d = CNT_W'(1);
      else if (hsync_i && hs_cnt_q != POS_MAX) hs_cnt_d = hs_cnt_q + CNT_W'(1);

      if (fall) hs_width_d = hs_cnt_q;

      if (rise) begin
        line_len_d = {1'b0, h_pos_q} + (CNT_W+1)'(1);
        // line_len_q still holds the previous line's measurement here.
        locked_d   = (line_len_d == line_len_q) && (h_pos_q != POS_MAX) &&
                     (hs_width_q != '0) &&
                     ({1'b0, hs_width_q} < (line_len_d >> 1));
      end else if (h_pos_d == POS_MAX) begin
        locked_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q  <= 1'b0;
      h_pos_q    <= '0;
      hs_cnt_q   <= '0;
      hs_width_q <= '0;
      line_len_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      if (ce_i) hs_prev_q <= hsync_i;
      h_pos_q    <= h_pos_d;
      hs_cnt_q   <= hs_cnt_d;
      hs_width_q <= hs_width_d;
      line_len_q <= line_len_d;
      locked_q   <= locked_d;
    end
  end

  assign h_pos_o    = h_pos_d;
  assign hs_width_o = hs_width_q;
  assign line_len_o = line_len_q;
  assign pos_sat_o  = (h_pos_d == POS_MAX);
  assign locked_o   = locked_q;

endmodule

// File: rtl/analogizer_csync_gen.sv
// Composite-sync generator: serrated csync during vsync once the line timing is
// locked, with hsync/vsync/de/RGB re-timed through the same single register stage.
module analogizer_csync_gen
  import analogizer_video_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter bit SERRATE = 1'b1
) (
  input logic                   clk,
  input logic                   reset_n,
  analogizer_csync_gen_if.slave vid
);

  logic [CNT_W-1:0] h_pos, hs_width;
  logic [CNT_W:0]   line_len;
  logic             pos_sat, locked;

  csync_line_meter #(.CNT_W(CNT_W)) u_meter (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce_i      (vid.ce),
    .hsync_i   (vid.hsync),
    .h_pos_o   (h_pos),
    .hs_width_o(hs_width),
    .line_len_o(line_len),
    .pos_sat_o (pos_sat),
    .locked_o  (locked)
  );

  // One extra bit keeps half + width from wrapping at the top of the range.
  logic [CNT_W:0] half, pos_x, width_x;
  logic           in_window, serrate_now;
  vid_out_t       out_q, out_d;

  always_comb begin
    half        = line_len >> 1;
    pos_x       = {1'b0, h_pos};
    width_x     = {1'b0, hs_width};
    in_window   = (pos_x < width_x) || ((pos_x >= half) && (pos_x < half + width_x));
    serrate_now = SERRATE && locked && !pos_sat && vid.vsync;

    out_d = out_q;
    if (vid.ce) begin
      out_d.hsync = vid.hsync;
      out_d.vsync = vid.vsync;
      out_d.de    = vid.de;
      out_d.rgb   = vid.din;
      if (serrate_now) out_d.csync = in_window ? ~SYNC_ACTIVE : SYNC_ACTIVE;
      else             out_d.csync = vid.hsync | vid.vsync;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else          out_q <= out_d;
  end

  assign vid.hsync_o = out_q.hsync;
  assign vid.vsync_o = out_q.vsync;
  assign vid.csync_o = out_q.csync;
  assign vid.de_o    = out_q.de;
  assign vid.dout    = out_q.rgb;
  assign vid.locked  = locked;

endmodule

// File: tb/tb_analogizer_csync_gen.sv
// Directed bench for analogizer_csync_gen: reset, lock, serration, unlock/relock,
// ce gating, wide hsync, position saturation and asynchronous reset mid-vsync.
module tb_analogizer_csync_gen;
  import analogizer_video_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  analogizer_csync_gen_if vif ();

  analogizer_csync_gen #(.CNT_W(12), .SERRATE(1'b1)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .vid    (vif.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Drive one clock's inputs while clk is low, then sample 1 time unit after the edge.
  task automatic step(input logic c, input logic h, input logic v, input logic d,
                      input rgb_t px);
    @(negedge clk);
    vif.ce = c; vif.hsync = h; vif.vsync = v; vif.de = d; vif.din = px;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    reset_n = 1'b1;
  endtask

  // One video line; lock_pre0 is the lock state during the rising-edge pixel,
  // lock_line the state after it. With gap set every ce pixel is followed by a
  // ce=0 clock carrying inverted inputs, across which outputs must hold.
  task automatic run_line(input string tag, input int len, input int width,
                          input logic vs, input logic lock_pre0, input logic lock_line,
                          input int half, input int wwin, input bit gap);
    for (int k = 0; k < len; k++) begin
      logic hs, de, lp, win, cs;
      rgb_t px;
      hs  = (k < width);
      de  = (k >= width + 4) && (k < len - 4);
      px  = 24'hA53CF0 ^ 24'(k);
      lp  = (k == 0) ? lock_pre0 : lock_line;
      win = (k < wwin) || ((k >= half) && (k < half + wwin));
      cs  = (vs && lp) ? ~win : (hs | vs);
      for (int g = 0; g <= (gap ? 1 : 0); g++) begin
        if (g == 0) step(1'b1, hs, vs, de, px);
        else        step(1'b0, ~hs, ~vs, ~de, ~px);
        n_checks += 6;
        if (vif.csync_o !== cs) begin
          n_errors++;
          $display("FAIL %s csync k=%0d g=%0d got %b exp %b", tag, k, g, vif.csync_o, cs);
        end
        if (vif.hsync_o !== hs) begin
          n_errors++;
          $display("FAIL %s hsync k=%0d g=%0d got %b exp %b", tag, k, g, vif.hsync_o, hs);
        end
        if (vif.vsync_o !== vs) begin
          n_errors++;
          $display("FAIL %s vsync k=%0d g=%0d got %b exp %b", tag, k, g, vif.vsync_o, vs);
        end
        if (vif.de_o !== de) begin
          n_errors++;
          $display("FAIL %s de k=%0d g=%0d got %b exp %b", tag, k, g, vif.de_o, de);
        end
        if (vif.dout !== px) begin
          n_errors++;
          $display("FAIL %s dout k=%0d g=%0d got %h exp %h", tag, k, g, vif.dout, px);
        end
        if (vif.locked !== lock_line) begin
          n_errors++;
          $display("FAIL %s locked k=%0d g=%0d got %b exp %b", tag, k, g, vif.locked, lock_line);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 24'($urandom));
      n_checks++;
      if ({vif.hsync_o, vif.vsync_o, vif.csync_o, vif.de_o, vif.locked, vif.dout} !== '0) begin
        n_errors++;
        $display("FAIL reset_hold got %b%b%b%b%b %h exp 00000 000000", vif.hsync_o,
                 vif.vsync_o, vif.csync_o, vif.de_o, vif.locked, vif.dout);
      end
    end
    reset_n = 1'b1;
    #1;
    n_checks++;
    if ({vif.hsync_o, vif.csync_o, vif.de_o, vif.dout} !== '0) begin
      n_errors++;
      $display("FAIL reset_release_early got outputs before first ce edge");
    end
    step(1'b1, 1'b1, 1'b0, 1'b1, 24'h123456);
    n_checks++;
    if ({vif.hsync_o, vif.vsync_o, vif.csync_o, vif.de_o, vif.locked} !== 5'b10110 ||
        vif.dout !== 24'h123456) begin
      n_errors++;
      $display("FAIL reset_first_out got %b%b%b%b%b %h exp 10110 123456", vif.hsync_o,
               vif.vsync_o, vif.csync_o, vif.de_o, vif.locked, vif.dout);
    end
  endtask

  task automatic test_lock();
    do_reset();
    run_line("lock_l1", 100, 8, 1'b0, 1'b0, 1'b0, 50, 8, 1'b0);
    run_line("lock_l2", 100, 8, 1'b0, 1'b0, 1'b0, 50, 8, 1'b0);
    run_line("lock_l3", 100, 8, 1'b0, 1'b0, 1'b1, 50, 8, 1'b0);
    run_line("lock_l4", 100, 8, 1'b0, 1'b1, 1'b1, 50, 8, 1'b0);
  endtask

  task automatic test_serration();
    for (int l = 0; l < 3; l++)
      run_line("serr_vs", 100, 8, 1'b1, 1'b1, 1'b1, 50, 8, 1'b0);
    run_line("serr_post", 100, 8, 1'b0, 1'b1, 1'b1, 50, 8, 1'b0);
  endtask

  task automatic test_unlock();
    run_line("unl_long", 120, 8, 1'b1, 1'b1, 1'b1, 50, 8, 1'b0);
    run_line("unl_drop", 120, 8, 1'b1, 1'b1, 1'b0, 60, 8, 1'b0);
    run_line("unl_relock", 120, 8, 1'b1, 1'b0, 1'b1, 60, 8, 1'b0);
    run_line("unl_post", 120, 8, 1'b0, 1'b1, 1'b1, 60, 8, 1'b0);
  endtask

  task automatic test_ce_gating();
    do_reset();
    run_line("ce_l1", 100, 8, 1'b0, 1'b0, 1'b0, 50, 8, 1'b1);
    run_line("ce_l2", 100, 8, 1'b0, 1'b0, 1'b0, 50, 8, 1'b1);
    run_line("ce_l3", 100, 8, 1'b0, 1'b0, 1'b1, 50, 8, 1'b1);
    run_line("ce_vs", 100, 8, 1'b1, 1'b1, 1'b1, 50, 8, 1'b1);
  endtask

  task automatic test_wide_hsync();
    do_reset();
    for (int l = 0; l < 4; l++)
      run_line("wide", 100, 60, 1'b0, 1'b0, 1'b0, 50, 60, 1'b0);
  endtask

  task automatic test_saturation();
    do_reset();
    run_line("sat_l1", 100, 8, 1'b1, 1'b0, 1'b0, 50, 8, 1'b0);
    run_line("sat_l2", 100, 8, 1'b1, 1'b0, 1'b0, 50, 8, 1'b0);
    run_line("sat_l3", 100, 8, 1'b1, 1'b0, 1'b1, 50, 8, 1'b0);
    for (int k = 0; k < 4200; k++) begin
      logic exp_lock, exp_cs, win;
      win      = (k < 8) || ((k >= 50) && (k < 58));
      exp_lock = (k <= 4094);
      exp_cs   = (k < 4095) ? ~win : 1'b1;
      step(1'b1, 1'(k < 8), 1'b1, 1'b0, '0);
      n_checks += 2;
      if (vif.locked !== exp_lock) begin
        n_errors++;
        $display("FAIL sat_locked k=%0d got %b exp %b", k, vif.locked, exp_lock);
      end
      if (vif.csync_o !== exp_cs) begin
        n_errors++;
        $display("FAIL sat_csync k=%0d got %b exp %b", k, vif.csync_o, exp_cs);
      end
    end
    run_line("sat_after1", 100, 8, 1'b1, 1'b0, 1'b0, 50, 8, 1'b0);
    run_line("sat_after2", 100, 8, 1'b1, 1'b0, 1'b0, 50, 8, 1'b0);
    run_line("sat_relock", 100, 8, 1'b1, 1'b0, 1'b1, 50, 8, 1'b0);
  endtask

  task automatic test_reset_mid_vsync();
    for (int k = 0; k <= 20; k++) step(1'b1, 1'(k < 8), 1'b1, 1'b1, 24'hFFFFFF);
    n_checks++;
    if ({vif.vsync_o, vif.csync_o, vif.locked} !== 3'b111) begin
      n_errors++;
      $display("FAIL midvs_pre got %b%b%b exp 111", vif.vsync_o, vif.csync_o, vif.locked);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({vif.hsync_o, vif.vsync_o, vif.csync_o, vif.de_o, vif.locked, vif.dout} !== '0) begin
      n_errors++;
      $display("FAIL midvs_async got %b%b%b%b%b %h exp 00000 000000", vif.hsync_o,
               vif.vsync_o, vif.csync_o, vif.de_o, vif.locked, vif.dout);
    end
    step(1'b1, 1'b1, 1'b1, 1'b1, 24'hFFFFFF);
    n_checks++;
    if ({vif.vsync_o, vif.csync_o, vif.locked, vif.dout} !== '0) begin
      n_errors++;
      $display("FAIL midvs_hold got %b%b%b %h exp 000 000000", vif.vsync_o,
               vif.csync_o, vif.locked, vif.dout);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    vif.ce = 1'b0; vif.hsync = 1'b0; vif.vsync = 1'b0; vif.de = 1'b0; vif.din = '0;
    test_reset();
    test_lock();
    test_serration();
    test_unlock();
    test_ce_gating();
    test_wide_hsync();
    test_saturation();
    test_reset_mid_vsync();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
